// File: rtl/test_seq_pkg.sv
// Shared types, result codes and width helper for the test stage sequencer.
package test_seq_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_END    = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_CHECK    = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;
    localparam logic [1:0] FC_SPURIOUS = 2'd3;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Clearable saturating up-counter; expired is high once the count reaches TIMEOUT-1.
module stage_watchdog
    import test_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
    localparam logic [W-1:0] PRE_LAST = W'(TIMEOUT - 2);

    logic [W-1:0] count;

    // Count while enabled, stop at the last value so the counter never wraps.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (enable && (count != LAST)) begin
            count   <= count + W'(1);
            expired <= (count == PRE_LAST);
        end
    end

endmodule

// File: rtl/test_stage_sequencer.sv
// Launches test stages in order, collects their verdicts and ends the run.
module test_stage_sequencer
    import test_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES    = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned TIMEOUT       = 1024,
    localparam int unsigned IDX_W        = (NUM_STAGES > 1) ? clog2(NUM_STAGES) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] stage_done,
    input  logic                  stage_pass,
    output logic                  finish,
    output logic                  fail,
    output logic [1:0]            fail_code,
    output logic [IDX_W-1:0]      fail_stage,
    output logic [31:0]           cycle_count
);

    localparam int unsigned SET_W = clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] next_idx;
    logic [SET_W-1:0] settle_cnt;
    logic             expired;
    logic             wd_clear;
    logic             wd_enable;
    logic             end_fail;
    logic [1:0]       end_code;
    logic [IDX_W-1:0] end_stage;
    logic             spur_found;
    logic [IDX_W-1:0] spur_idx;

    assign wd_clear  = (state == ST_LAUNCH);
    assign wd_enable = (state == ST_WAIT);

    stage_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(expired)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_SETTLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decision and end-of-run result, spurious done has top priority.
    always_comb begin
        next_state = state;
        next_idx   = idx;
        end_fail   = 1'b0;
        end_code   = FC_NONE;
        end_stage  = '0;
        spur_found = 1'b0;
        spur_idx   = '0;

        for (int j = 0; j < int'(NUM_STAGES); j++) begin
            if (!spur_found && stage_done[j] && (IDX_W'(j) != idx)) begin
                spur_found = 1'b1;
                spur_idx   = IDX_W'(j);
            end
        end

        case (state)
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    next_state = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (spur_found) begin
                    next_state = ST_END;
                    end_fail   = 1'b1;
                    end_code   = FC_SPURIOUS;
                    end_stage  = spur_idx;
                end else if (stage_done[idx]) begin
                    if (!stage_pass) begin
                        next_state = ST_END;
                        end_fail   = 1'b1;
                        end_code   = FC_CHECK;
                        end_stage  = idx;
                    end else if (idx == LAST_IDX) begin
                        next_state = ST_END;
                    end else begin
                        next_idx   = idx + IDX_W'(1);
                        next_state = ST_LAUNCH;
                    end
                end else if (expired) begin
                    next_state = ST_END;
                    end_fail   = 1'b1;
                    end_code   = FC_TIMEOUT;
                    end_stage  = idx;
                end
            end
            ST_END: begin
                next_state = ST_END;
            end
            default: begin
                next_state = ST_SETTLE;
            end
        endcase
    end

    // Index, settle timer, registered outputs and the frozen verdict.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx         <= '0;
            settle_cnt  <= '0;
            stage_start <= '0;
            finish      <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= FC_NONE;
            fail_stage  <= '0;
            cycle_count <= '0;
        end else begin
            idx <= next_idx;
            if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end
            if (next_state == ST_LAUNCH) begin
                stage_start <= NUM_STAGES'(1) << next_idx;
            end else begin
                stage_start <= '0;
            end
            if ((state != ST_END) && (next_state == ST_END)) begin
                finish     <= 1'b1;
                fail       <= end_fail;
                fail_code  <= end_code;
                fail_stage <= end_stage;
            end
            if ((next_state != ST_END) && (cycle_count != '1)) begin
                cycle_count <= cycle_count + 32'd1;
            end
        end
    end

endmodule
